obstacle_scheduler: RTL

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

---
 rtl/game_pkg.sv | 22 ++
 rtl/tick_gen.sv | 22 ++
 rtl/obstacle_scheduler.sv | 110 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants for the game controller: scheduler state encodings,
// obstacle LFSR seed/taps and the smallest allowed base gap.
package game_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_REQ  = 2'd3;

  // x^16 + x^14 + x^13 + x^11 + 1, bit 15 is the x^16 stage
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MIN_GAP = 16;

  // Fibonacci step: shift towards the MSB, feedback enters at bit 0.
  // A non-zero state never maps to zero with a maximal-length polynomial.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running game tick: one-cycle pulse every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic Clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Down-counter reloading to TICK_DIV-1 after reaching zero
  always_ff @(posedge Clock) begin
    if (reset || cnt == '0) cnt <= CW'(TICK_DIV - 1);
    else                    cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: waits a pseudo-random number of game ticks (shrinking
// with difficulty level) while the game is active, then requests an
// obstacle from the control FSM and holds the request until acknowledged.
//
//   state  | meaning
//   IDLE   | no game running, waiting for reset_game to drop
//   ARM    | load gap counter from level base + random offset
//   WAIT   | count gap down on active ticks
//   REQ    | gen high, waiting for create_obs
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int TICK_DIV        = CLOCK_FREQUENCY / 60,
  parameter int BASE_GAP        = 90,
  parameter int GAP_STEP        = 8
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       ld_game,
  input  logic       calc_jump,
  input  logic       create_obs,
  input  logic       reset_game,
  output logic       gen,
  output logic [1:0] obs_type,
  output logic [2:0] level,
  output logic [7:0] obs_count
);

  logic [1:0]  state, state_nxt;
  logic [7:0]  gap;
  logic [7:0]  gap_load;
  logic [15:0] lfsr;
  logic        reset_game_q;
  logic        tick;
  logic        active;
  int          base_raw;

  assign active = ld_game | calc_jump;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clock (Clock),
    .reset (reset),
    .tick  (tick)
  );

  // Randomness source; survives reset_game so successive games differ
  always_ff @(posedge Clock) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  // Level-dependent base gap, clamped, plus a 0..31 tick random offset
  always_comb begin
    base_raw = BASE_GAP - GAP_STEP * int'(level);
    if (base_raw < MIN_GAP) base_raw = MIN_GAP;
    gap_load = 8'(base_raw + int'(lfsr[4:0]));
  end

  // Next-state decode; reset_game overrides everything, including an ack
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (reset_game_q && !reset_game) state_nxt = S_ARM;
      S_ARM:   state_nxt = S_WAIT;
      S_WAIT:  if (active && gap == 8'd0) state_nxt = S_REQ;
      S_REQ:   if (create_obs) state_nxt = S_ARM;
      default: state_nxt = S_IDLE;
    endcase
    if (reset_game) state_nxt = S_IDLE;
  end

  // State, registered gen, gap counter and obstacle bookkeeping
  always_ff @(posedge Clock) begin
    if (reset) begin
      state        <= S_IDLE;
      gen          <= 1'b0;
      obs_type     <= 2'd0;
      level        <= 3'd0;
      obs_count    <= 8'd0;
      gap          <= 8'd0;
      reset_game_q <= 1'b0;
    end else begin
      reset_game_q <= reset_game;
      state        <= state_nxt;
      gen          <= (state_nxt == S_REQ);
      if (reset_game) begin
        gap       <= 8'd0;
        obs_count <= 8'd0;
        level     <= 3'd0;
      end else begin
        case (state)
          S_ARM:  gap <= gap_load;
          S_WAIT: if (tick && active && gap != 8'd0) gap <= gap - 1'b1;
          S_REQ: begin
            if (create_obs) begin
              obs_type <= lfsr[6:5];
              if (obs_count != 8'hFF) begin
                obs_count <= obs_count + 1'b1;
                if (obs_count[2:0] == 3'b111 && level != 3'd7) level <= level + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
